// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Grants are combinational; read data returns one cycle after a legal read grant.
module mem_port_arbiter #(
  parameter int unsigned AW    = 6,
  parameter int unsigned RR_EN = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [31:0]   p0_addr,
  input  logic [31:0]   p0_wdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [31:0]   p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p0_gnt,
  output logic          p1_gnt,
  output logic          p0_rvalid,
  output logic          p1_rvalid,
  output logic [31:0]   p0_rdata,
  output logic [31:0]   p1_rdata,
  output logic          p0_err,
  output logic          p1_err,
  output logic          p0_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [15:0]   p0_cnt,
  output logic [15:0]   p1_cnt
);

  typedef enum logic {StIdle, StRdPend} rd_state_e;

  rd_state_e   state_q, state_d;
  logic        pend_port_q, pend_port_d;
  logic        last_gnt_q, last_gnt_d;
  logic [15:0] p0_cnt_q, p1_cnt_q;
  logic        gnt0, gnt1, any_gnt, legal0, legal1, sel_legal, sel_we;

  assign legal0 = (p0_addr[1:0] == 2'b00) && ((p0_addr >> (AW + 2)) == 32'd0);
  assign legal1 = (p1_addr[1:0] == 2'b00) && ((p1_addr >> (AW + 2)) == 32'd0);

  // Grants are forced low while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (p0_req && p1_req) begin
        if ((RR_EN != 0) && !last_gnt_q) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = p0_req;
        gnt1 = p1_req;
      end
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_legal = gnt1 ? legal1 : legal0;
  assign sel_we    = gnt1 ? p1_we : p0_we;

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_err    = gnt0 & ~legal0;
  assign p1_err    = gnt1 & ~legal1;
  assign p0_stall  = p0_req & ~gnt0;

  assign mem_en    = any_gnt & sel_legal;
  assign mem_we    = mem_en & sel_we;
  assign mem_addr  = gnt1 ? p1_addr[AW+1:2] : p0_addr[AW+1:2];
  assign mem_wdata = gnt1 ? p1_wdata : p0_wdata;

  // Each read occupies the pending slot for exactly one cycle.
  always_comb begin
    state_d     = StIdle;
    pend_port_d = pend_port_q;
    last_gnt_d  = last_gnt_q;
    if (any_gnt) begin
      last_gnt_d = gnt1;
    end
    if (mem_en && !sel_we) begin
      state_d     = StRdPend;
      pend_port_d = gnt1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pend_port_q <= 1'b0;
      last_gnt_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_port_q <= pend_port_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0_cnt_q <= '0;
      p1_cnt_q <= '0;
    end else begin
      if (mem_en && gnt0 && (p0_cnt_q != 16'hFFFF)) begin
        p0_cnt_q <= p0_cnt_q + 16'd1;
      end
      if (mem_en && gnt1 && (p1_cnt_q != 16'hFFFF)) begin
        p1_cnt_q <= p1_cnt_q + 16'd1;
      end
    end
  end

  assign p0_cnt    = p0_cnt_q;
  assign p1_cnt    = p1_cnt_q;
  assign p0_rvalid = (state_q == StRdPend) && !pend_port_q;
  assign p1_rvalid = (state_q == StRdPend) && pend_port_q;
  assign p0_rdata  = p0_rvalid ? mem_rdata : 32'd0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin and fixed-priority instances share stimulus
// and are checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 6;
  localparam int unsigned LIM = 1 << (AW + 2);

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

  logic [1:0]    gnt0, gnt1, rv0, rv1, err0, err1, stall0, men, mwe;
  logic [AW-1:0] maddr [2];
  logic [31:0]   mwd [2], rd0 [2], rd1 [2];
  logic [15:0]   cnt0 [2], cnt1 [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // m=0: fixed priority, m=1: round robin; each with its own memory.
  for (genvar m = 0; m < 2; m++) begin : g_dut
    logic [31:0] mem [64];
    logic [31:0] mrd;
    bit          ini;

    mem_port_arbiter #(.AW(AW), .RR_EN(m)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .p0_req   (p0_req),
      .p0_we    (p0_we),
      .p0_addr  (p0_addr),
      .p0_wdata (p0_wdata),
      .p1_req   (p1_req),
      .p1_we    (p1_we),
      .p1_addr  (p1_addr),
      .p1_wdata (p1_wdata),
      .p0_gnt   (gnt0[m]),
      .p1_gnt   (gnt1[m]),
      .p0_rvalid(rv0[m]),
      .p1_rvalid(rv1[m]),
      .p0_rdata (rd0[m]),
      .p1_rdata (rd1[m]),
      .p0_err   (err0[m]),
      .p1_err   (err1[m]),
      .p0_stall (stall0[m]),
      .mem_en   (men[m]),
      .mem_we   (mwe[m]),
      .mem_addr (maddr[m]),
      .mem_wdata(mwd[m]),
      .mem_rdata(mrd),
      .p0_cnt   (cnt0[m]),
      .p1_cnt   (cnt1[m])
    );

    always @(posedge clk) begin
      if (!ini) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        mrd <= 32'd0;
        ini <= 1'b1;
      end else if (men[m]) begin
        if (mwe[m]) mem[maddr[m]] <= mwd[m];
        else        mrd <= mem[maddr[m]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state, one copy per instance.
  logic        mlast [2];
  logic        mpv [2];
  logic        mpp [2];
  logic [31:0] mpd [2];
  int          mc0 [2];
  int          mc1 [2];
  logic [31:0] mmem [2][64];
  bit          minit;

  always @(negedge clk) begin : cmp
    int          gp;
    logic [31:0] ga, gd;
    logic        gw, lg, en;
    logic [5:0]  ix;
    if (!minit) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 64; i++) mmem[k][i] = 32'd0;
      minit = 1'b1;
    end
    for (int m = 0; m < 2; m++) begin
      if (!reset) begin
        chk($sformatf("m%0d_rst_gnt0", m), gnt0[m], 0);
        chk($sformatf("m%0d_rst_gnt1", m), gnt1[m], 0);
        chk($sformatf("m%0d_rst_err", m), {err1[m], err0[m]}, 0);
        chk($sformatf("m%0d_rst_mem", m), {mwe[m], men[m]}, 0);
        chk($sformatf("m%0d_rst_rv", m), {rv1[m], rv0[m]}, 0);
        chk($sformatf("m%0d_rst_rd0", m), rd0[m], 0);
        chk($sformatf("m%0d_rst_rd1", m), rd1[m], 0);
        chk($sformatf("m%0d_rst_cnt", m), {cnt1[m], cnt0[m]}, 0);
        mlast[m] = 1'b1;
        mpv[m]   = 1'b0;
        mc0[m]   = 0;
        mc1[m]   = 0;
      end else begin
        if (p0_req && p1_req) gp = (m == 1 && mlast[m] == 1'b0) ? 1 : 0;
        else if (p0_req)      gp = 0;
        else if (p1_req)      gp = 1;
        else                  gp = -1;
        ga = (gp == 1) ? p1_addr : p0_addr;
        gd = (gp == 1) ? p1_wdata : p0_wdata;
        gw = (gp == 1) ? p1_we : p0_we;
        lg = (ga[1:0] == 2'b00) && (ga < LIM);
        en = (gp >= 0) && lg;
        chk($sformatf("m%0d_gnt0", m), gnt0[m], gp == 0);
        chk($sformatf("m%0d_gnt1", m), gnt1[m], gp == 1);
        chk($sformatf("m%0d_err0", m), err0[m], gp == 0 && !lg);
        chk($sformatf("m%0d_err1", m), err1[m], gp == 1 && !lg);
        chk($sformatf("m%0d_stall", m), stall0[m], p0_req && gp != 0);
        chk($sformatf("m%0d_mem_en", m), men[m], en);
        chk($sformatf("m%0d_mem_we", m), mwe[m], en && gw);
        if (en) chk($sformatf("m%0d_mem_addr", m), maddr[m], ga[7:2]);
        if (en && gw) chk($sformatf("m%0d_mem_wdata", m), mwd[m], gd);
        chk($sformatf("m%0d_rv0", m), rv0[m], mpv[m] && !mpp[m]);
        chk($sformatf("m%0d_rv1", m), rv1[m], mpv[m] && mpp[m]);
        chk($sformatf("m%0d_rd0", m), rd0[m], (mpv[m] && !mpp[m]) ? mpd[m] : 32'd0);
        chk($sformatf("m%0d_rd1", m), rd1[m], (mpv[m] && mpp[m]) ? mpd[m] : 32'd0);
        chk($sformatf("m%0d_cnt0", m), cnt0[m], mc0[m]);
        chk($sformatf("m%0d_cnt1", m), cnt1[m], mc1[m]);
        if (gp >= 0) mlast[m] = (gp == 1);
        mpv[m] = 1'b0;
        if (en) begin
          ix = ga[7:2];
          if (gp == 0 && mc0[m] < 65535) mc0[m]++;
          if (gp == 1 && mc1[m] < 65535) mc1[m]++;
          if (gw) begin
            mmem[m][ix] = gd;
          end else begin
            mpv[m] = 1'b1;
            mpp[m] = (gp == 1);
            mpd[m] = mmem[m][ix];
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic drv0(input logic we, input logic [31:0] a, input logic [31:0] d);
    p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d;
  endtask

  task automatic drv1(input logic we, input logic [31:0] a, input logic [31:0] d);
    p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d;
  endtask

  logic [5:0] rr_g0, rr_g1, rr_st, fp_g0, fp_g1, fp_st;

  initial begin
    reset = 0;
    idle();
    p0_req = 1;
    repeat (2) cyc();

    // Write 15 to word 0, read it back.
    reset = 1;
    idle();
    drv0(1, 32'h0, 32'd15);
    @(negedge clk);
    chk("lit_wr_gnt", gnt0, 2'b11);
    cyc();
    drv0(0, 32'h0, 32'd0);
    @(negedge clk);
    chk("lit_rd_gnt", gnt0, 2'b11);
    cyc();
    idle();
    @(negedge clk);
    chk("lit_rd_rv", rv0, 2'b11);
    chk("lit_rd_data_rr", rd0[1], 32'd15);
    chk("lit_rd_data_fp", rd0[0], 32'd15);
    cyc();
    drv0(1, 32'h4, 32'h0A0A);
    cyc();
    idle();
    drv1(1, 32'h8, 32'h0B0B);
    cyc();

    // Read granted, then reset in the following cycle.
    idle();
    drv0(0, 32'h4, 32'd0);
    cyc();
    reset = 0;
    idle();
    @(negedge clk);
    chk("lit_rst_kill_rv", rv0, 2'b00);
    cyc();
    reset = 1;
    drv0(0, 32'h4, 32'd0);
    drv1(0, 32'h8, 32'd0);
    @(negedge clk);
    chk("lit_post_rst_rv", rv0, 2'b00);
    chk("lit_post_rst_cnt_rr", {cnt1[1], cnt0[1]}, 32'd0);
    chk("lit_post_rst_cnt_fp", {cnt1[0], cnt0[0]}, 32'd0);

    // Both ports read continuously for 6 cycles.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      rr_g0[i] = gnt0[1]; rr_g1[i] = gnt1[1]; rr_st[i] = stall0[1];
      fp_g0[i] = gnt0[0]; fp_g1[i] = gnt1[0]; fp_st[i] = stall0[0];
      cyc();
    end
    idle();
    @(negedge clk);
    chk("lit_rr_g0", rr_g0, 6'b010101);
    chk("lit_rr_g1", rr_g1, 6'b101010);
    chk("lit_rr_stall", rr_st, 6'b101010);
    chk("lit_fp_g0", fp_g0, 6'b111111);
    chk("lit_fp_g1", fp_g1, 6'b000000);
    chk("lit_fp_stall", fp_st, 6'b000000);
    chk("lit_rr_cnt", {cnt1[1], cnt0[1]}, {16'd3, 16'd3});
    chk("lit_fp_cnt", {cnt1[0], cnt0[0]}, {16'd0, 16'd6});

    // Illegal p1 requests: misaligned, then out of range.
    cyc();
    drv1(0, 32'h2, 32'd0);
    @(negedge clk);
    chk("lit_mis_gnt", gnt1, 2'b11);
    chk("lit_mis_err", err1, 2'b11);
    chk("lit_mis_en", men, 2'b00);
    cyc();
    drv1(0, 32'h100, 32'd0);
    @(negedge clk);
    chk("lit_oor_gnt", gnt1, 2'b11);
    chk("lit_oor_err", err1, 2'b11);
    chk("lit_oor_en", men, 2'b00);
    cyc();
    idle();
    @(negedge clk);
    chk("lit_ill_rv", rv1, 2'b00);
    chk("lit_ill_cnt_rr", cnt1[1], 16'd3);
    chk("lit_ill_cnt_fp", cnt1[0], 16'd0);

    // Write then read the same word back to back.
    cyc();
    drv1(1, 32'hC, 32'h77);
    cyc();
    idle();
    drv0(0, 32'hC, 32'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("lit_raw_rr", rd0[1], 32'h77);
    chk("lit_raw_fp", rd0[0], 32'h77);
    cyc();
    drv0(1, 32'h10, 32'd5);
    drv1(0, 32'h10, 32'd0);
    repeat (2) cyc();
    idle();
    cyc();

    // Counter saturation.
    drv0(0, 32'h0, 32'd0);
    repeat (70000) cyc();
    idle();
    @(negedge clk);
    chk("lit_sat_rr", cnt0[1], 16'hFFFF);
    chk("lit_sat_fp", cnt0[0], 16'hFFFF);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
